// File: rtl/creek_run_ctrl_pkg.sv
// Shared constants for the creek run controller: FSM state codes, CSR offsets, STATUS bit positions.
package creek_run_ctrl_pkg;

  typedef logic [1:0] run_state_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_WRCNT  = 2'd2;
  localparam logic [1:0] CSR_CSUM   = 2'd3;

  localparam int STS_RUN      = 0;
  localparam int STS_PAUSED   = 1;
  localparam int STS_WAITING  = 2;
  localparam int STS_ERR_DROP = 3;
  localparam int STS_ERR_TMO  = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/creek_run_fsm.sv
// Run/halt sequencer for the creek core with a DRAIN timeout counter.
// state | meaning: RUN core running | DRAIN halt requested, awaiting waiting | PAUSED core halted | RESUME released, awaiting waiting=0
module creek_run_fsm
  import creek_run_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       waiting,
  output run_state_t state,
  output logic       pause_n,
  output logic       tmo
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pause_n_q, pause_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!run) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // A halt confirmation in the last allowed cycle still wins over the timeout.
        if (waiting) begin
          state_d = ST_PAUSED;
        end else if (cnt_q == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (run) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        if (!waiting) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
    endcase
    pause_n_d = (state_d == ST_RUN) || (state_d == ST_RESUME);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_DRAIN;
      cnt_q     <= '0;
      pause_n_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pause_n_q <= pause_n_d;
    end
  end

  assign state   = state_q;
  assign pause_n = pause_n_q;

endmodule

// File: rtl/creek_run_ctrl.sv
// HPS-facing Avalon-MM controller: CSRs, halted-only instr_mem write gating, write counters.
// Optional CSUM accumulator enabled by defining CREEK_RUN_CTRL_CSUM_EN.
module creek_run_ctrl
  import creek_run_ctrl_pkg::*;
#(
  parameter int IADDR_W = 10,
  parameter int IDATA_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IADDR_W:0]   avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  output logic               avs_waitrequest,
  output logic [IADDR_W-1:0] instr_writeaddr,
  output logic [IDATA_W-1:0] instr_writedata,
  output logic               instr_write,
  output logic               pause_n,
  input  logic               waiting
);

  run_state_t state;
  logic       tmo;

  logic               run_q, run_d;
  logic               err_drop_q, err_drop_d;
  logic               err_tmo_q, err_tmo_d;
  logic [15:0]        wrcount_q, wrcount_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               instr_write_q, instr_write_d;
  logic [IADDR_W-1:0] iaddr_q, iaddr_d;
  logic [IDATA_W-1:0] idata_q, idata_d;

  logic        csr_sel, mem_wr, ctrl_wr, clr, stall, accept, drop;
  logic [1:0]  csr_off;
  logic [31:0] status, csum_rd;
  logic        unused_wdata;

  creek_run_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run_d),
    .waiting (waiting),
    .state   (state),
    .pause_n (pause_n),
    .tmo     (tmo)
  );

  assign csr_sel      = avs_address[IADDR_W];
  assign csr_off      = avs_address[1:0];
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    mem_wr  = avs_write & ~csr_sel;
    ctrl_wr = avs_write & csr_sel & (csr_off == CSR_CTRL);
    clr     = ctrl_wr & avs_writedata[1];
    stall   = mem_wr & (state == ST_DRAIN) & ~tmo;
    accept  = mem_wr & (state == ST_PAUSED);
    drop    = mem_wr & ~stall & ~accept;

    run_d      = ctrl_wr ? avs_writedata[0] : run_q;
    err_drop_d = (err_drop_q & ~clr) | drop;
    err_tmo_d  = (err_tmo_q & ~clr) | tmo;
    wrcount_d  = clr ? 16'd0 : (accept ? sat_inc16(wrcount_q) : wrcount_q);

    instr_write_d = accept;
    iaddr_d       = accept ? avs_address[IADDR_W-1:0] : iaddr_q;
    idata_d       = accept ? avs_writedata[IDATA_W-1:0] : idata_q;

    status = 32'd0;
    status[STS_RUN]      = (state == ST_RUN);
    status[STS_PAUSED]   = (state == ST_PAUSED);
    status[STS_WAITING]  = waiting;
    status[STS_ERR_DROP] = err_drop_q;
    status[STS_ERR_TMO]  = err_tmo_q;

    readdata_d = 32'd0;
    if (avs_read && csr_sel) begin
      case (csr_off)
        CSR_CTRL:   readdata_d = {31'd0, run_q};
        CSR_STATUS: readdata_d = status;
        CSR_WRCNT:  readdata_d = {16'd0, wrcount_q};
        default:    readdata_d = csum_rd;
      endcase
    end
  end

`ifdef CREEK_RUN_CTRL_CSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr) csum_d = 16'd0;
    else if (accept) csum_d = csum_q + 16'(avs_writedata[IDATA_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) csum_q <= 16'd0;
    else          csum_q <= csum_d;
  end

  assign csum_rd = {16'd0, csum_q};
`else
  assign csum_rd = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      err_drop_q    <= 1'b0;
      err_tmo_q     <= 1'b0;
      wrcount_q     <= 16'd0;
      readdata_q    <= 32'd0;
      instr_write_q <= 1'b0;
      iaddr_q       <= '0;
      idata_q       <= '0;
    end else begin
      run_q         <= run_d;
      err_drop_q    <= err_drop_d;
      err_tmo_q     <= err_tmo_d;
      wrcount_q     <= wrcount_d;
      readdata_q    <= readdata_d;
      instr_write_q <= instr_write_d;
      iaddr_q       <= iaddr_d;
      idata_q       <= idata_d;
    end
  end

  // Gating with reset_n kills a pulse already launched when reset lands in its cycle.
  assign instr_write     = instr_write_q & reset_n;
  assign instr_writeaddr = iaddr_q;
  assign instr_writedata = idata_q;
  assign avs_readdata    = readdata_q;
  assign avs_waitrequest = stall & reset_n;

endmodule
